// File: rtl/mcu_bus_ctrl.sv
// mcu_bus_ctrl: table-decoded N-slave bus controller with ready handshake, timeout and error log
module mcu_bus_ctrl #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int N_SLV = 4,
  parameter logic [N_SLV*AW-1:0] BASE = {N_SLV{AW'(0)}},
  parameter logic [N_SLV*AW-1:0] MASK = {N_SLV{AW'(0)}},
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic m_req,
  input  logic m_read,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic m_busy,
  output logic m_done,
  output logic m_err,
  output logic [DW-1:0] m_rdata,
  output logic [N_SLV-1:0] s_cs,
  output logic s_read,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [N_SLV*DW-1:0] s_rdata,
  input  logic [N_SLV-1:0] s_ready,
  input  logic err_clr,
  output logic [AW-1:0] err_addr,
  output logic [7:0] err_cnt
);
  localparam int SW = N_SLV > 1 ? $clog2(N_SLV) : 1;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, hit_idx;
  logic hit, enter_err;
  logic [AW-1:0] eaddr;
  logic [7:0] cnt_q, cnt_d;
  logic [N_SLV-1:0] s_cs_q, s_cs_d;
  logic s_read_q, s_read_d, m_busy_q, m_busy_d, m_done_q, m_done_d, m_err_q, m_err_d;
  logic [AW-1:0] s_addr_q, s_addr_d, err_addr_q, err_addr_d;
  logic [DW-1:0] s_wdata_q, s_wdata_d, m_rdata_q, m_rdata_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  assign m_busy = m_busy_q;
  assign m_done = m_done_q;
  assign m_err = m_err_q;
  assign m_rdata = m_rdata_q;
  assign s_cs = s_cs_q;
  assign s_read = s_read_q;
  assign s_addr = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign err_addr = err_addr_q;
  assign err_cnt = err_cnt_q;
  // address decode: scan downward so the lowest matching slave index wins
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--)
      if ((m_addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  // next state, registered outputs and error log
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    s_cs_d = s_cs_q;
    s_read_d = s_read_q;
    s_addr_d = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_busy_d = m_busy_q;
    m_done_d = 1'b0;
    m_err_d = 1'b0;
    m_rdata_d = m_rdata_q;
    enter_err = 1'b0;
    eaddr = s_addr_q;
    case (state_q)
      IDLE: if (m_req) begin
        s_read_d = m_read;
        s_addr_d = m_addr;
        s_wdata_d = m_wdata;
        m_busy_d = 1'b1;
        eaddr = m_addr;
        if (hit) begin
          sel_d = hit_idx;
          cnt_d = '0;
          s_cs_d = N_SLV'(1) << hit_idx;
          state_d = ACCESS;
        end else begin
          m_done_d = 1'b1;
          m_err_d = 1'b1;
          enter_err = 1'b1;
          state_d = ERR;
        end
      end
      ACCESS: if (s_ready[sel_q]) begin
        m_rdata_d = s_read_q ? s_rdata[int'(sel_q)*DW +: DW] : m_rdata_q;
        s_cs_d = '0;
        m_done_d = 1'b1;
        state_d = DONE;
      end else if (cnt_q == TLAST) begin
        s_cs_d = '0;
        m_done_d = 1'b1;
        m_err_d = 1'b1;
        enter_err = 1'b1;
        state_d = ERR;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: begin
        m_busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    err_cnt_d = enter_err ? (err_clr ? 8'd1 : (err_cnt_q == 8'hFF ? err_cnt_q : err_cnt_q + 8'd1))
                          : (err_clr ? 8'd0 : err_cnt_q);
    err_addr_d = enter_err ? eaddr : (err_clr ? '0 : err_addr_q);
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      s_cs_q <= '0;
      s_read_q <= 1'b0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      m_busy_q <= 1'b0;
      m_done_q <= 1'b0;
      m_err_q <= 1'b0;
      m_rdata_q <= '0;
      err_addr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      s_cs_q <= s_cs_d;
      s_read_q <= s_read_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_busy_q <= m_busy_d;
      m_done_q <= m_done_d;
      m_err_q <= m_err_d;
      m_rdata_q <= m_rdata_d;
      err_addr_q <= err_addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: doc/mcu_bus_ctrl.md
# mcu_bus_ctrl

Parametrised bus controller for the MCU core. It sits between the control unit and its memory-mapped slaves: RAM, ROM, GPR file, external/peripheral memory, and future peripherals. It replaces fixed per-slave chip-selects and the shared tri-state data bus with three things:
- a table-driven address decoder for N slaves;
- separate read/write data paths;
- a ready handshake with a timeout that reports bus errors instead of hanging the core.

## Interface
Parameters:
- AW, 16, address width.
- DW, 16, data width.
- N_SLV, 4, number of slave ports (1..16).
- BASE, {N_SLV{AW'h0}}, flat N_SLV*AW vector; slice i is the base address of slave i.
- MASK, {N_SLV{AW'h0}}, flat N_SLV*AW vector; slave i hits when (m_addr & MASK[i]) == BASE[i].
- TIMEOUT, 15, maximum cycles a slave may hold ready low (1..255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- m_req  in  1  master request; sampled only when m_busy=0.
- m_read  in  1  1=read, 0=write; latched with m_req.
- m_addr  in  AW  access address; latched with m_req.
- m_wdata  in  DW  write data; latched with m_req.
- m_busy  out  1  high from acceptance until the cycle after m_done.
- m_done  out  1  one-cycle pulse ending every accepted access.
- m_err  out  1  high together with m_done when the access failed.
- m_rdata  out  DW  read data; valid while m_done=1 and m_err=0; held until the next read completes.
- s_cs  out  N_SLV  one-hot slave select.
- s_read  out  1  direction to slaves.
- s_addr  out  AW  latched address.
- s_wdata  out  DW  latched write data.
- s_rdata  in  N_SLV*DW  per-slave read data; slice i belongs to slave i.
- s_ready  in  N_SLV  per-slave ready.
- err_clr  in  1  clears err_addr and err_cnt.
- err_addr  out  AW  address of the most recent failed access.
- err_cnt  out  8  saturating count of failed accesses.

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - On m_req=1, latch m_read, m_addr and m_wdata, and set m_busy=1.
  - Decode the address. The lowest index i with a hit wins, so overlapping regions resolve to the lower index.
  - On a hit, load sel=i, clear the wait counter, and go to ACCESS.
  - On no hit, go to ERR. No s_cs is asserted.
- ACCESS:
  - s_cs[sel]=1 and all other s_cs bits are 0.
  - s_read, s_addr and s_wdata are driven from the latches.
  - If s_ready[sel]=1, capture s_rdata slice sel into m_rdata (reads only) and go to DONE.
  - Else, if cnt==TIMEOUT-1, go to ERR.
  - Otherwise cnt+1.
  - The ready bits of non-selected slaves are ignored.
- DONE: s_cs=0, m_done=1, m_err=0; go to IDLE.
- ERR:
  - s_cs=0, m_done=1, m_err=1.
  - err_addr is loaded from the latched address.
  - err_cnt increments, saturating at 255.
  - Go to IDLE. m_rdata is unchanged.
- err_clr=1 zeroes err_addr and err_cnt. If an ERR update happens in the same cycle, the increment wins: err_cnt=1 and err_addr is the new address.
- m_req asserted while m_busy=1 is ignored. The master must re-present the request.

## Timing
- Reset (reset=0 at an edge): state=IDLE, and every output is 0 (s_cs, s_read, s_addr, s_wdata, m_busy, m_done, m_err, m_rdata, err_addr, err_cnt). Reset asserted mid-access aborts the access with no m_done and no error logged.
- All outputs are registered.
- Edge E0 samples m_req in IDLE. s_cs rises after E0.
- A slave ready sampled at edge Ek (k>=1) gives m_done high for the cycle after Ek. Minimum latency is 2 cycles from request edge to done; s_cs is high exactly k cycles.
- Timeout: with ready held low, s_cs stays high for exactly TIMEOUT cycles and m_done/m_err pulse in the next cycle. Ready arriving on the final allowed cycle wins, and the access completes normally.
- Decode miss: m_done/m_err are high in the cycle after E0, and s_cs never rises.
- m_busy falls together with m_done's falling edge. The earliest next accept is the edge after DONE/ERR, so back-to-back accesses take 3 cycles minimum each.

## Test plan
- Defaults with BASE={0x0000,0x4000,0x8000,0xC000} and MASK=4x0xC000. Read 0x4012 with slave 1 ready at once and s_rdata[1]=0xBEEF → s_cs=0010 for 1 cycle, then m_done=1, m_err=0, m_rdata=0xBEEF; total 2 cycles.
- Write 0x8004, data 0x1234, slave 2 ready after 3 wait cycles → s_wdata=0x1234, s_read=0, s_cs=0100 for 4 cycles, then m_done; m_rdata unchanged.
- Slave 3 never ready, TIMEOUT=15 → s_cs high exactly 15 cycles, then m_done=m_err=1, err_addr=address, err_cnt=1. A repeat with ready on cycle 15 gives m_err=0.
- Slave 0 MASK=0 with BASE=0xFFFF, so no region matches 0x1000 → m_err pulse 1 cycle after the request, s_cs stays 0. 256 misses leave err_cnt=255. err_clr together with a miss gives err_cnt=1.
- Overlapping regions: slaves 0 and 1 both hit 0x0010 → only s_cs[0] asserts. A stray s_ready[1] pulse during the access is ignored.
- Reset asserted in the 2nd wait cycle of an access → next cycle all outputs 0 and no m_done. A new request afterwards completes normally.
